aes_encr_sequencer: RTL and testbench

AES_ENCR_SEQUENCER -- requirements
Module: aes_encr_sequencer

---
 rtl/aes_encr_sequencer.sv | 163 ++++++++++++++++
 tb/tb_aes_encr_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encr_sequencer.sv
// ---------------------------------------------------------------------------
// aes_encr_sequencer
//
// Purpose: Sequences one AES encryption through a shared, externally built
// round datapath. It does the initial AddRoundKey itself, then iterates
// rounds 1..NR by feeding its state register to the datapath and presenting
// the matching round-key index to an external key-array mux. The finished
// ciphertext is held until the consumer accepts it.
//
// Configuration macro: AES_SEQ_OVERLAP_EN
//   undefined : a finished block must return to IDLE before the next one is
//               accepted (one block per NR+2 cycles).
//   defined   : a new block may be accepted in the same cycle the previous
//               ciphertext retires (one block per NR+1 cycles).
//
// Parameters:
//   NR  number of AES rounds (1..15)
//   N   block / round-key width in bits
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   in_valid       in   plaintext offered
//   in_ready       out  plaintext can be accepted
//   in_plaintext   in   plaintext block
//   out_valid      out  ciphertext held
//   out_ready      in   consumer accepts ciphertext
//   out_ciphertext out  ciphertext block
//   rk_idx         out  round-key index for the key-array mux
//   rk_data        in   round key selected by rk_idx (combinational)
//   dp_state_o     out  state fed to the round datapath
//   dp_final_o     out  selects the final-round datapath (no MixColumns)
//   dp_state_i     in   round result with AddRoundKey(rk_data) applied
//   busy           out  high while a block is in RUN or DONE
//   blk_count      out  completed output handshakes, wraps at 16 bits
// ---------------------------------------------------------------------------
module aes_encr_sequencer #(
  parameter int NR = 10,
  parameter int N  = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [N-1:0] rk_data,
  output logic [N-1:0] dp_state_o,
  output logic         dp_final_o,
  input  logic [N-1:0] dp_state_i,
  output logic         busy,
  output logic [15:0]  blk_count
);

  localparam logic [3:0] LP_NR = 4'(NR);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_dp_state;
  logic [N-1:0]   w_dp_state_next;
  logic [3:0]     r_rnd;
  logic [3:0]     w_rnd_next;
  logic [N-1:0]   r_ct;
  logic [N-1:0]   w_ct_next;
  logic [15:0]    r_blk_count;
  logic [15:0]    w_blk_count_next;
  logic           w_load;

  always_comb begin
    w_state_next     = r_state;
    w_dp_state_next  = r_dp_state;
    w_rnd_next       = r_rnd;
    w_ct_next        = r_ct;
    w_blk_count_next = r_blk_count;
    w_load           = 1'b0;
    in_ready         = 1'b0;
    out_valid        = 1'b0;
    rk_idx           = 4'd0;
    dp_final_o       = 1'b0;
    busy             = 1'b0;

    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        w_load   = in_valid;
      end
      RUN: begin
        busy            = 1'b1;
        rk_idx          = r_rnd;
        dp_final_o      = (r_rnd == LP_NR);
        w_dp_state_next = dp_state_i;
        if (r_rnd == LP_NR) begin
          // Final round result is captured straight into the output holding
          // register so the state register is free for the next block.
          w_ct_next    = dp_state_i;
          w_rnd_next   = 4'd0;
          w_state_next = DONE;
        end else begin
          w_rnd_next = r_rnd + 4'd1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_blk_count_next = r_blk_count + 16'd1;
          w_state_next     = IDLE;
        end
`ifdef AES_SEQ_OVERLAP_EN
        // Accept only when the held ciphertext retires in the same cycle,
        // so out_ciphertext is never overwritten while still pending.
        in_ready = out_ready;
        w_load   = in_valid & out_ready;
`endif
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Block load: rk_idx is 0 in every state that can accept, so rk_data is
    // the initial round key here.
    if (w_load) begin
      w_dp_state_next = in_plaintext ^ rk_data;
      w_rnd_next      = 4'd1;
      w_state_next    = RUN;
    end

    if (rst) begin
      in_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dp_state  <= '0;
      r_rnd       <= 4'd0;
      r_ct        <= '0;
      r_blk_count <= 16'd0;
    end else begin
      r_state     <= w_state_next;
      r_dp_state  <= w_dp_state_next;
      r_rnd       <= w_rnd_next;
      r_ct        <= w_ct_next;
      r_blk_count <= w_blk_count_next;
    end
  end

  assign out_ciphertext = r_ct;
  assign dp_state_o     = r_dp_state;
  assign blk_count      = r_blk_count;

endmodule

// File: tb/tb_aes_encr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_encr_sequencer
//
// Directed bench for aes_encr_sequencer (NR=10, N=128). The round datapath
// and key array are modelled here: either a stub (state + 1, zero keys) or a
// behavioural AES-128 round with an on-the-fly key schedule for the
// FIPS-197 vector. Honour AES_SEQ_OVERLAP_EN the same way as the RTL build.
// ---------------------------------------------------------------------------
module tb_aes_encr_sequencer;

`ifdef AES_SEQ_OVERLAP_EN
  localparam int   EXP_GAP = 11;
  localparam logic OVL     = 1'b1;
`else
  localparam int   EXP_GAP = 12;
  localparam logic OVL     = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [127:0] dp_state_o;
  logic         dp_final_o;
  logic [127:0] dp_state_i;
  logic         busy;
  logic [15:0]  blk_count;

  logic         real_mode = 1'b0;
  logic [7:0]   sbox_t [256];
  logic [127:0] rk_arr [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_encr_sequencer #(.NR(10), .N(128)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_plaintext(in_plaintext),
    .out_valid(out_valid), .out_ready(out_ready), .out_ciphertext(out_ciphertext),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .dp_state_o(dp_state_o), .dp_final_o(dp_final_o), .dp_state_i(dp_state_i),
    .busy(busy), .blk_count(blk_count)
  );

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    for (int i = 1; i < 256; i++) begin
      if (gmul(v, 8'(i)) == 8'h01) inv = 8'(i);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st,
                                             input logic [127:0] rk,
                                             input logic fin);
    logic [7:0]   b  [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox_t[st[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[r+4*c] = b[r + 4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = gmul(8'h02, sr[4*c]) ^ gmul(8'h03, sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ gmul(8'h02, sr[4*c+1]) ^ gmul(8'h03, sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul(8'h02, sr[4*c+2]) ^ gmul(8'h03, sr[4*c+3]);
      mc[4*c+3] = gmul(8'h03, sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul(8'h02, sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = (fin ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
    return res;
  endfunction

  task automatic build_keys(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_arr[r] = '0;
    for (int r = 0; r < 11; r++) rk_arr[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  assign rk_data    = real_mode ? rk_arr[rk_idx] : 128'h0;
  assign dp_state_i = real_mode ? aes_round(dp_state_o, rk_data, dp_final_o) : dp_state_o + 128'd1;

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [127:0] pt);
    in_valid     = 1'b1;
    in_plaintext = pt;
    step();
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_plaintext = '0;
    step(); step();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_ciphertext !== 128'h0) begin errors++; $display("FAIL rst_ct: got %h want 0", out_ciphertext); end
    checks++; if (dp_state_o !== 128'h0) begin errors++; $display("FAIL rst_state: got %h want 0", dp_state_o); end
    checks++; if (blk_count !== 16'h0) begin errors++; $display("FAIL rst_blk_count: got %h want 0", blk_count); end
    checks++; if ({busy, dp_final_o, rk_idx} !== 6'b0) begin errors++; $display("FAIL rst_ctrl: got busy=%b final=%b idx=%0d want 0", busy, dp_final_o, rk_idx); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_stub_rounds();
    logic [127:0] pt;
    pt = 128'h0123456789abcdef_fedcba9876543210;
    out_ready = 1'b0;
    start_block(pt);
    for (int k = 1; k <= 10; k++) begin
      #1;
      checks++;
      if (rk_idx !== 4'(k) || dp_final_o !== (k == 10) || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stub_round%0d: got idx=%0d final=%b busy=%b in_ready=%b out_valid=%b want idx=%0d final=%b busy=1 in_ready=0 out_valid=0",
                 k, rk_idx, dp_final_o, busy, in_ready, out_valid, k, (k == 10));
      end
      checks++;
      if (dp_state_o !== pt + 128'(k - 1)) begin errors++; $display("FAIL stub_state%0d: got %h want %h", k, dp_state_o, pt + 128'(k - 1)); end
      step();
    end
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stub_latency: out_valid got %b want 1", out_valid); end
    checks++; if (out_ciphertext !== pt + 128'd10) begin errors++; $display("FAIL stub_ct: got %h want %h", out_ciphertext, pt + 128'd10); end
    checks++; if (rk_idx !== 4'd0 || dp_final_o !== 1'b0) begin errors++; $display("FAIL stub_done_ctrl: got idx=%0d final=%b want 0 0", rk_idx, dp_final_o); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== OVL) begin errors++; $display("FAIL stub_done_in_ready: got %b want %b", in_ready, OVL); end
    step();
    checks++; if (blk_count !== 16'd1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stub_retire: got cnt=%0d out_valid=%b busy=%b want 1 0 0", blk_count, out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt;
    int n;
    pt = 128'hdeadbeef_00000000_cafef00d_ffffffff;
    out_ready = 1'b0;
    start_block(pt);
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    checks++; if (n !== 10) begin errors++; $display("FAIL bp_latency: got %0d cycles want 10", n); end
    in_valid = 1'b1;
    in_plaintext = 128'h5555;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_ciphertext !== pt + 128'd10 || in_ready !== 1'b0 || blk_count !== 16'd1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b ct=%h in_ready=%b cnt=%0d busy=%b want 1 %h 0 1 1",
                 c, out_valid, out_ciphertext, in_ready, blk_count, busy, pt + 128'd10);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (blk_count !== 16'd2 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: got cnt=%0d valid=%b busy=%b want 2 0 0", blk_count, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    out_ready = 1'b1;
    start_block(128'h1111);
    step(); step(); step(); step();
    checks++; if (rk_idx !== 4'd5) begin errors++; $display("FAIL midrst_idx: got %0d want 5", rk_idx); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
    step();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || blk_count !== 16'd0 || rk_idx !== 4'd0) begin
      errors++; $display("FAIL midrst_state: got busy=%b valid=%b cnt=%0d idx=%0d want 0 0 0 0", busy, out_valid, blk_count, rk_idx);
    end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) seen++;
      step();
    end
    checks++; if (seen !== 0 || blk_count !== 16'd0) begin errors++; $display("FAIL midrst_no_output: got outs=%0d cnt=%0d want 0 0", seen, blk_count); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] base;
    int hs;
    int outs;
    int out_cyc [4];
    base = 128'h00000000_11111111_22222222_33333300;
    hs = 0; outs = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 80 && outs < 4; c++) begin
      in_valid     = (hs < 4);
      in_plaintext = base + 128'(hs);
      #1;
      if (out_valid) begin
        out_cyc[outs] = c;
        checks++;
        if (out_ciphertext !== base + 128'(outs) + 128'd10) begin
          errors++; $display("FAIL b2b_ct%0d: got %h want %h", outs, out_ciphertext, base + 128'(outs) + 128'd10);
        end
        outs++;
      end
      if (in_valid && in_ready) hs++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (outs !== 4) begin errors++; $display("FAIL b2b_count: got %0d outputs want 4", outs); end
    else begin
      checks++; if (out_cyc[0] !== 11) begin errors++; $display("FAIL b2b_first: got cycle %0d want 11", out_cyc[0]); end
      for (int j = 1; j < 4; j++) begin
        checks++;
        if (out_cyc[j] - out_cyc[j-1] !== EXP_GAP) begin
          errors++; $display("FAIL b2b_gap%0d: got %0d want %0d", j, out_cyc[j] - out_cyc[j-1], EXP_GAP);
        end
      end
    end
    #1;
    checks++; if (blk_count !== 16'd4) begin errors++; $display("FAIL b2b_blk_count: got %0d want 4", blk_count); end
  endtask

  task automatic test_fips();
    int n;
    real_mode = 1'b1;
    out_ready = 1'b0;
    start_block(128'h00112233445566778899aabbccddeeff);
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    checks++; if (n + 1 !== 11) begin errors++; $display("FAIL fips_latency: got %0d want 11", n + 1); end
    checks++; if (out_ciphertext !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      errors++; $display("FAIL fips_ct: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", out_ciphertext);
    end
    out_ready = 1'b1;
    step();
    real_mode = 1'b0;
    checks++; if (blk_count !== 16'd5) begin errors++; $display("FAIL fips_blk_count: got %0d want 5", blk_count); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_cnt;
    int n;
    // Preset the counter near its top instead of running 65536 blocks.
    force dut.r_blk_count = 16'hfffd;
    #1;
    release dut.r_blk_count;
    exp_cnt = 16'hfffd;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      start_block(128'(b));
      n = 0;
      while (!out_valid && n < 30) begin step(); n++; end
      step();
      exp_cnt = exp_cnt + 16'd1;
      checks++; if (blk_count !== exp_cnt) begin errors++; $display("FAIL wrap%0d: got %h want %h", b, blk_count, exp_cnt); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_plaintext = '0;
    for (int i = 0; i < 256; i++) sbox_t[i] = calc_sbox(8'(i));
    build_keys(128'h000102030405060708090a0b0c0d0e0f);
    test_reset();
    test_stub_rounds();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_fips();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
